// File: rtl/beta_control_fsm.sv
// Multi-cycle Beta control sequencer: FETCH/EXEC(/MEM) with a req/ack data-memory port,
// bounded memory timeout and boundary-only IRQ. Define BETA_ILLOP_TRAP_EN to trap undefined opcodes.
module beta_control_fsm #(
  parameter int OPCODE_W    = 6,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                Z,
  input  logic                irq,
  input  logic                supervisor,
  input  logic                dmem_ack,
  output logic [3:0]          alufn,
  output logic                asel,
  output logic                bsel,
  output logic                moe,
  output logic                mwr,
  output logic                ra2sel,
  output logic                wasel,
  output logic                werf,
  output logic [1:0]          wdsel,
  output logic [2:0]          pcsel,
  output logic                pc_en,
  output logic                ir_en,
  output logic                dmem_req,
  output logic                mem_err
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MEM_TIMEOUT - 1);

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_MUL = 4'h2;
  localparam logic [3:0] ALU_AND = 4'h3;
  localparam logic [3:0] ALU_OR  = 4'h4;
  localparam logic [3:0] ALU_XOR = 4'h5;
  localparam logic [3:0] ALU_SHL = 4'h6;
  localparam logic [3:0] ALU_SHR = 4'h7;
  localparam logic [3:0] ALU_BUF = 4'h8;

  localparam logic [OPCODE_W-1:0] OP_LD   = OPCODE_W'(6'h18);
  localparam logic [OPCODE_W-1:0] OP_ST   = OPCODE_W'(6'h19);
  localparam logic [OPCODE_W-1:0] OP_JMP  = OPCODE_W'(6'h1B);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'h1C);
  localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(6'h1D);
  localparam logic [OPCODE_W-1:0] OP_LDR  = OPCODE_W'(6'h1F);
  localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(6'h20);
  localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(6'h21);
  localparam logic [OPCODE_W-1:0] OP_MUL  = OPCODE_W'(6'h22);
  localparam logic [OPCODE_W-1:0] OP_AND  = OPCODE_W'(6'h28);
  localparam logic [OPCODE_W-1:0] OP_OR   = OPCODE_W'(6'h29);
  localparam logic [OPCODE_W-1:0] OP_XOR  = OPCODE_W'(6'h2A);
  localparam logic [OPCODE_W-1:0] OP_SHL  = OPCODE_W'(6'h2C);
  localparam logic [OPCODE_W-1:0] OP_SHR  = OPCODE_W'(6'h2D);
  localparam logic [OPCODE_W-1:0] OP_ADDC = OPCODE_W'(6'h30);
  localparam logic [OPCODE_W-1:0] OP_SUBC = OPCODE_W'(6'h31);
  localparam logic [OPCODE_W-1:0] OP_MULC = OPCODE_W'(6'h32);
  localparam logic [OPCODE_W-1:0] OP_ANDC = OPCODE_W'(6'h38);
  localparam logic [OPCODE_W-1:0] OP_ORC  = OPCODE_W'(6'h39);
  localparam logic [OPCODE_W-1:0] OP_XORC = OPCODE_W'(6'h3A);
  localparam logic [OPCODE_W-1:0] OP_SHLC = OPCODE_W'(6'h3C);
  localparam logic [OPCODE_W-1:0] OP_SHRC = OPCODE_W'(6'h3D);

  typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_IRQ, S_TRAP} state_t;

  state_t              state_q;
  logic [OPCODE_W-1:0] op_q;
  logic                irq_pend_q, irq_pend_d;
  logic [CNT_W-1:0]    to_cnt_q;

  logic       is_alu, is_cvar, is_ld, is_ldr, is_st, is_jmp, is_beq, is_bne;
  logic       is_mem, is_undef, take_irq, mem_timeout;
  logic [3:0] alu_fn;

  always_comb begin
    is_alu  = 1'b0;
    is_cvar = 1'b0;
    is_ld   = 1'b0;
    is_ldr  = 1'b0;
    is_st   = 1'b0;
    is_jmp  = 1'b0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    alu_fn  = ALU_ADD;
    case (op_q)
      OP_ADD:  begin is_alu = 1'b1; alu_fn = ALU_ADD; end
      OP_SUB:  begin is_alu = 1'b1; alu_fn = ALU_SUB; end
      OP_MUL:  begin is_alu = 1'b1; alu_fn = ALU_MUL; end
      OP_AND:  begin is_alu = 1'b1; alu_fn = ALU_AND; end
      OP_OR:   begin is_alu = 1'b1; alu_fn = ALU_OR;  end
      OP_XOR:  begin is_alu = 1'b1; alu_fn = ALU_XOR; end
      OP_SHL:  begin is_alu = 1'b1; alu_fn = ALU_SHL; end
      OP_SHR:  begin is_alu = 1'b1; alu_fn = ALU_SHR; end
      OP_ADDC: begin is_alu = 1'b1; is_cvar = 1'b1; alu_fn = ALU_ADD; end
      OP_SUBC: begin is_alu = 1'b1; is_cvar = 1'b1; alu_fn = ALU_SUB; end
      OP_MULC: begin is_alu = 1'b1; is_cvar = 1'b1; alu_fn = ALU_MUL; end
      OP_ANDC: begin is_alu = 1'b1; is_cvar = 1'b1; alu_fn = ALU_AND; end
      OP_ORC:  begin is_alu = 1'b1; is_cvar = 1'b1; alu_fn = ALU_OR;  end
      OP_XORC: begin is_alu = 1'b1; is_cvar = 1'b1; alu_fn = ALU_XOR; end
      OP_SHLC: begin is_alu = 1'b1; is_cvar = 1'b1; alu_fn = ALU_SHL; end
      OP_SHRC: begin is_alu = 1'b1; is_cvar = 1'b1; alu_fn = ALU_SHR; end
      OP_LD:   is_ld  = 1'b1;
      OP_LDR:  is_ldr = 1'b1;
      OP_ST:   is_st  = 1'b1;
      OP_JMP:  is_jmp = 1'b1;
      OP_BEQ:  is_beq = 1'b1;
      OP_BNE:  is_bne = 1'b1;
      default: ;
    endcase
  end

  assign is_mem      = is_ld | is_ldr | is_st;
  assign is_undef    = ~(is_alu | is_mem | is_jmp | is_beq | is_bne);
  assign take_irq    = irq_pend_q & ~supervisor;
  assign mem_timeout = (state_q == S_MEM) & ~dmem_ack & (to_cnt_q == TO_LAST);
  // A new request arriving in the S_IRQ cycle re-arms the pending flag.
  assign irq_pend_d  = (state_q == S_IRQ) ? irq : (irq_pend_q | irq);

  always_comb begin
    alufn    = ALU_ADD;
    asel     = 1'b0;
    bsel     = 1'b0;
    moe      = 1'b0;
    mwr      = 1'b0;
    ra2sel   = 1'b0;
    wasel    = 1'b0;
    werf     = 1'b0;
    wdsel    = 2'd0;
    pcsel    = 3'd0;
    pc_en    = 1'b0;
    ir_en    = 1'b0;
    dmem_req = 1'b0;
    mem_err  = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: ir_en = ~take_irq;
        S_EXEC: begin
          if (is_alu) begin
            alufn = alu_fn;
            bsel  = is_cvar;
            wdsel = 2'd1;
            werf  = 1'b1;
            pc_en = 1'b1;
          end else if (is_beq | is_bne) begin
            pcsel = {2'b00, is_beq ? Z : ~Z};
            werf  = 1'b1;
            pc_en = 1'b1;
          end else if (is_jmp) begin
            pcsel = 3'd2;
            werf  = 1'b1;
            pc_en = 1'b1;
          end else if (is_mem) begin
            alufn = is_ldr ? ALU_BUF : ALU_ADD;
            asel  = is_ldr;
            bsel  = ~is_ldr;
          end else if (is_undef) begin
`ifdef BETA_ILLOP_TRAP_EN
            pc_en = 1'b0;
`else
            pc_en = 1'b1;
`endif
          end
        end
        S_MEM: begin
          alufn    = is_ldr ? ALU_BUF : ALU_ADD;
          asel     = is_ldr;
          bsel     = ~is_ldr;
          dmem_req = 1'b1;
          mwr      = is_st;
          ra2sel   = is_st;
          moe      = ~is_st;
          if (dmem_ack) begin
            pc_en = 1'b1;
            werf  = ~is_st;
            wdsel = is_st ? 2'd0 : 2'd2;
          end else begin
            mem_err = mem_timeout;
          end
        end
        S_IRQ: begin
          pcsel = 3'd4;
          wasel = 1'b1;
          werf  = 1'b1;
          pc_en = 1'b1;
        end
        S_TRAP: begin
          pcsel = 3'd3;
          wasel = 1'b1;
          werf  = 1'b1;
          pc_en = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      op_q       <= '0;
      irq_pend_q <= 1'b0;
      to_cnt_q   <= '0;
    end else begin
      irq_pend_q <= irq_pend_d;
      case (state_q)
        S_FETCH: begin
          if (take_irq) begin
            state_q <= S_IRQ;
          end else begin
            op_q    <= opcode;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_mem) begin
            state_q  <= S_MEM;
            to_cnt_q <= '0;
          end
`ifdef BETA_ILLOP_TRAP_EN
          else if (is_undef) begin
            state_q <= S_TRAP;
          end
`endif
          else begin
            state_q <= S_FETCH;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            state_q <= S_FETCH;
          end else if (mem_timeout) begin
            state_q <= S_TRAP;
          end else begin
            to_cnt_q <= to_cnt_q + CNT_W'(1);
          end
        end
        S_IRQ:   state_q <= S_FETCH;
        S_TRAP:  state_q <= S_FETCH;
        default: state_q <= S_FETCH;
      endcase
    end
  end

endmodule
